dct_seq_ctrl: RTL and testbench

Parametrised sequencer for the N x N 2-D transform datapath in the MPEG pipeline.
- For each output point (x,y) it clears the accumulator and streams all N*N input/coefficient indices (u,v) to memory at one read per cycle.
- It drives a MAC enable delayed by the memory/multiplier latency, then presents the result with a valid/ready handshake.
- It supports row- or column-major scan order and abort, and sits between the block buffer ROM/RAM and the MAC/accumulator unit.

---
 rtl/dct_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dct_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dct_seq_ctrl.sv
// Sequencer for the N x N 2-D transform: for every output point it clears the
// accumulator, streams all (u,v) reads, waits out the MAC latency and hands off the result.
module dct_seq_ctrl #(
  parameter int LOG2N   = 3,
  parameter int MAC_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 abort,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 rd_en,
  output logic [2*LOG2N-1:0]   address,
  output logic [LOG2N-1:0]     u,
  output logic [LOG2N-1:0]     v,
  output logic                 acc_clr,
  output logic                 mac_en,
  output logic                 out_valid,
  output logic [LOG2N-1:0]     out_x,
  output logic [LOG2N-1:0]     out_y,
  output logic                 done
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_OUT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [LOG2N-1:0]   u_q, u_d, v_q, v_d;
  logic [LOG2N-1:0]   x_q, x_d, y_q, y_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [MAC_LAT-1:0] mac_pipe_q, mac_pipe_d;
  logic               busy_q, busy_d;
  logic               acc_clr_q, acc_clr_d;
  logic               rd_en_q, rd_en_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    u_d      = u_q;
    v_d      = v_q;
    x_d      = x_q;
    y_d      = y_q;
    drain_d  = drain_q;
    mac_pipe_d    = '0;
    mac_pipe_d[0] = rd_en_q;
    for (int unsigned i = 1; i < MAC_LAT; i++) begin
      mac_pipe_d[i] = mac_pipe_q[i-1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          mode_d  = mode;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_CLR: begin
        u_d     = '0;
        v_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!mode_q) begin
          v_d = v_q + 1'b1;
          if (v_q == '1) u_d = u_q + 1'b1;
        end else begin
          u_d = u_q + 1'b1;
          if (u_q == '1) v_d = v_q + 1'b1;
        end
        if (u_q == '1 && v_q == '1) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_OUT;
        else                       drain_d = drain_q + 1'b1;
      end
      S_OUT: begin
        if (out_ready) begin
          if (x_q == '1 && y_q == '1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLR;
            u_d     = '0;
            v_d     = '0;
            if (!mode_q) begin
              y_d = y_q + 1'b1;
              if (y_q == '1) x_d = x_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
              if (x_q == '1) y_d = y_q + 1'b1;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the state decided, including an OUT acceptance.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      mac_pipe_d = '0;
    end

    if (state_d == S_IDLE) begin
      u_d     = '0;
      v_d     = '0;
      x_d     = '0;
      y_d     = '0;
      drain_d = '0;
    end

    busy_d      = (state_d != S_IDLE);
    acc_clr_d   = (state_d == S_CLR);
    rd_en_d     = (state_d == S_ISSUE);
    out_valid_d = (state_d == S_OUT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      u_q         <= '0;
      v_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      drain_q     <= '0;
      mac_pipe_q  <= '0;
      busy_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      u_q         <= u_d;
      v_q         <= v_d;
      x_q         <= x_d;
      y_q         <= y_d;
      drain_q     <= drain_d;
      mac_pipe_q  <= mac_pipe_d;
      busy_q      <= busy_d;
      acc_clr_q   <= acc_clr_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign address   = {u_q, v_q};
  assign u         = u_q;
  assign v         = v_q;
  assign acc_clr   = acc_clr_q;
  assign mac_en    = mac_pipe_q[MAC_LAT-1];
  assign out_valid = out_valid_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Scoreboard bench for dct_seq_ctrl: an 8x8/lat-2 instance and a 4x4/lat-1 instance.
module tb_dct_seq_ctrl;

  localparam int NA  = 8;
  localparam int LA  = 2;
  localparam int NNA = NA * NA;
  localparam int PA  = NNA + LA + 2;
  localparam int BIG = 1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in = 1'b1;
  logic       start = 1'b0, mode = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic       busy, rd_en, acc_clr, mac_en, out_valid, done;
  logic [5:0] address;
  logic [2:0] u, v, out_x, out_y;

  logic       start2 = 1'b0, mode2 = 1'b0, abort2 = 1'b0, out_ready2 = 1'b1;
  logic       busy2, rd_en2, acc_clr2, mac_en2, out_valid2, done2;
  logic [3:0] address2;
  logic [1:0] u2, v2, out_x2, out_y2;

  dct_seq_ctrl #(.LOG2N(3), .MAC_LAT(2)) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .mode(mode), .abort(abort),
    .out_ready(out_ready), .busy(busy), .rd_en(rd_en), .address(address),
    .u(u), .v(v), .acc_clr(acc_clr), .mac_en(mac_en), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .done(done)
  );

  dct_seq_ctrl #(.LOG2N(2), .MAC_LAT(1)) dut_small (
    .clk(clk), .rst_in(rst_in), .start(start2), .mode(mode2), .abort(abort2),
    .out_ready(out_ready2), .busy(busy2), .rd_en(rd_en2), .address(address2),
    .u(u2), .v(v2), .acc_clr(acc_clr2), .mac_en(mac_en2), .out_valid(out_valid2),
    .out_x(out_x2), .out_y(out_y2), .done(done2)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int t0      = 0;
  int rd2_cnt = 0;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t rd_q[$], mac_q[$], clr_q[$], rise_q[$], acc_q[$], done_q[$];
  ev_t acc2_q[$], done2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string name, ref ev_t q[$], input int val);
    ev_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected output at edge %0d value %0d", name, edge_n, val);
    end else begin
      e = q.pop_front();
      check({name, "_cycle"}, 64'(edge_n), 64'(e.cyc));
      check({name, "_value"}, 64'(val), 64'(e.val));
    end
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rd_en)                   sb_pop("rd", rd_q, int'(address));
    if (mac_en)                  sb_pop("mac_en", mac_q, 0);
    if (acc_clr)                 sb_pop("acc_clr", clr_q, 0);
    if (out_valid && !prev_valid) sb_pop("valid_rise", rise_q, 0);
    if (out_valid && out_ready)  sb_pop("accept", acc_q, int'(out_x) * 16 + int'(out_y));
    if (done)                    sb_pop("done", done_q, 0);
    prev_valid = out_valid;
  end

  always @(negedge clk) begin
    if (out_valid2 && out_ready2) sb_pop("b_accept", acc2_q, int'(out_x2) * 16 + int'(out_y2));
    if (done2)                    sb_pop("b_done", done2_q, 0);
    if (rd_en2)                   rd2_cnt++;
  end

  function automatic logic [63:0] outs_a();
    return 64'({busy, rd_en, address, u, v, acc_clr, mac_en, out_valid, out_x, out_y, done});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int rel);
    while (edge_n < t0 + rel) tick(1);
  endtask

  // Expected events for a block started at t0, dropping anything after cycle lim.
  task automatic plan(input bit m, input int stall, input int lim);
    int base, c, a, x, y;
    for (int k = 0; k < NNA; k++) begin
      base = t0 + k * PA + ((k > 0) ? stall : 0);
      if (base + 1 <= t0 + lim) clr_q.push_back('{base + 1, 0});
      for (int i = 0; i < NNA; i++) begin
        c = base + 2 + i;
        a = m ? ((i % NA) * NA + i / NA) : i;
        if (c <= t0 + lim)      rd_q.push_back('{c, a});
        if (c + LA <= t0 + lim) mac_q.push_back('{c + LA, 0});
      end
      x = m ? (k % NA) : (k / NA);
      y = m ? (k / NA) : (k % NA);
      if (base + PA <= t0 + lim) rise_q.push_back('{base + PA, 0});
      c = base + PA + ((k == 0) ? stall : 0);
      if (c <= t0 + lim) acc_q.push_back('{c, x * 16 + y});
    end
    c = t0 + NNA * PA + stall + 1;
    if (c <= t0 + lim) done_q.push_back('{c, 0});
  endtask

  task automatic begin_block(input bit m, input int stall, input int lim);
    start = 1'b1;
    mode  = m;
    t0    = edge_n;
    plan(m, stall, lim);
    tick(1);
    start = 1'b0;
  endtask

  task automatic abort_at(input int rel);
    wait_to(rel);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  task automatic leftover(input string name);
    check(name, 64'(rd_q.size() + mac_q.size() + clr_q.size() + rise_q.size()
                    + acc_q.size() + done_q.size()), 64'd0);
  endtask

  initial begin
    tick(3);
    check("reset_outputs", outs_a(), 64'd0);
    rst_in = 1'b0;
    tick(2);

    // Row-major, always ready.
    begin_block(1'b0, 0, BIG);
    wait_to(NNA * PA + 2);
    check("rowmajor_busy_after_done", 64'(busy), 64'd0);
    leftover("rowmajor_leftover");
    tick(3);

    // Column-major.
    begin_block(1'b1, 0, BIG);
    wait_to(NNA * PA + 2);
    check("colmajor_busy_after_done", 64'(busy), 64'd0);
    leftover("colmajor_leftover");
    tick(3);

    // Back-pressure for 10 cycles at the first result.
    out_ready = 1'b0;
    begin_block(1'b0, 10, BIG);
    wait_to(PA + 10);
    out_ready = 1'b1;
    wait_to(NNA * PA + 12);
    check("stall_busy_after_done", 64'(busy), 64'd0);
    leftover("stall_leftover");
    tick(3);

    // Abort mid-ISSUE, then a fresh block aborted after its first result.
    begin_block(1'b0, 0, 30);
    abort_at(30);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_mac_en", 64'(mac_en), 64'd0);
    tick(5);
    leftover("abort_leftover");
    begin_block(1'b0, 0, PA + 2);
    abort_at(PA + 2);
    check("abort2_busy", 64'(busy), 64'd0);
    tick(5);
    leftover("abort2_leftover");

    // Start while busy is ignored; reset mid-block; mode re-latched on next start.
    begin_block(1'b1, 0, 100);
    wait_to(50);
    start = 1'b1;
    mode  = 1'b0;
    tick(1);
    start = 1'b0;
    wait_to(100);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    check("midreset_outputs", outs_a(), 64'd0);
    tick(5);
    leftover("midreset_leftover");
    begin_block(1'b0, 0, PA + 2);
    abort_at(PA + 2);
    tick(5);
    leftover("relatch_leftover");

    // 4x4, MAC latency 1: 19-cycle points, done at 305.
    start2 = 1'b1;
    t0     = edge_n;
    for (int k = 0; k < 16; k++) acc2_q.push_back('{t0 + (k + 1) * 19, (k / 4) * 16 + (k % 4)});
    done2_q.push_back('{t0 + 305, 0});
    tick(1);
    start2 = 1'b0;
    wait_to(306);
    check("small_busy_after_done", 64'(busy2), 64'd0);
    check("small_read_count", 64'(rd2_cnt), 64'd256);
    check("small_leftover", 64'(acc2_q.size() + done2_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
